// File: rtl/polyvec_reduce_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : polyvec_reduce_arbiter_pkg
// Purpose  : Shared Kyber constants and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package polyvec_reduce_arbiter_pkg;

    localparam int KYBER_N       = 256;
    localparam int KYBER_Q       = 3329;
    localparam int KYBER_K       = 2;
    localparam int KYBER_COEFF_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/polyvec_reduce_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : polyvec_reduce_arbiter_pick
// Purpose  : Combinational winner select. POLYVEC_REDUCE_ARB_RR_EN selects
//            round-robin from i_ptr+1, otherwise lowest index wins.
// Revision : 1.0
// ============================================================================
module polyvec_reduce_arbiter_pick
    import polyvec_reduce_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
`ifdef POLYVEC_REDUCE_ARB_RR_EN
    input  logic [ID_W-1:0]    i_ptr,
`endif
    output logic [NUM_REQ-1:0] o_grant_onehot,
    output logic [ID_W-1:0]    o_grant_id
);

`ifdef POLYVEC_REDUCE_ARB_RR_EN
    int   w_idx;
    logic w_found;

    // Walk the ring starting one past the last winner; first valid wins.
    always_comb begin
        o_grant_onehot = '0;
        o_grant_id     = '0;
        w_found        = 1'b0;
        w_idx          = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req_valid[w_idx]) begin
                w_found               = 1'b1;
                o_grant_id            = ID_W'(w_idx);
                o_grant_onehot[w_idx] = 1'b1;
            end
        end
    end
`else
    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        o_grant_onehot = '0;
        o_grant_id     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                o_grant_onehot    = '0;
                o_grant_onehot[i] = 1'b1;
                o_grant_id        = ID_W'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/polyvec_reduce_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : polyvec_reduce_arbiter
// Purpose  : Shares one multi-cycle coefficient reducer among NUM_REQ
//            requesters. POLYVEC_REDUCE_ARB_RR_EN enables round-robin.
// Revision : 1.0
// ============================================================================
module polyvec_reduce_arbiter
    import polyvec_reduce_arbiter_pkg::*;
#(
    parameter int NUM_REQ = KYBER_K,
    parameter int COEFF_W = KYBER_COEFF_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*COEFF_W-1:0] req_coeff,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [COEFF_W-1:0]         rsp_coeff,
    output logic                       red_enable,
    output logic [COEFF_W-1:0]         red_coeff,
    input  logic                       red_done,
    input  logic [COEFF_W-1:0]         red_result,
    output logic                       busy
);

    localparam logic [NUM_REQ-1:0] c_ONEHOT_LSB = NUM_REQ'(1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_id_nxt;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [NUM_REQ-1:0] w_req_ready_nxt;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [NUM_REQ-1:0] w_rsp_valid_nxt;
    logic [COEFF_W-1:0] r_red_coeff;
    logic [COEFF_W-1:0] w_red_coeff_nxt;
    logic [COEFF_W-1:0] r_rsp_coeff;
    logic [COEFF_W-1:0] w_rsp_coeff_nxt;
    logic               r_red_enable;
    logic               w_red_enable_nxt;
    logic               w_grant;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [ID_W-1:0]    w_pick_id;

`ifdef POLYVEC_REDUCE_ARB_RR_EN
    logic [ID_W-1:0]    r_ptr;
`endif

    polyvec_reduce_arbiter_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req_valid    (req_valid),
`ifdef POLYVEC_REDUCE_ARB_RR_EN
        .i_ptr          (r_ptr),
`endif
        .o_grant_onehot (w_pick_onehot),
        .o_grant_id     (w_pick_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low, operands hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_id_nxt         = r_id;
        w_req_ready_nxt  = '0;
        w_rsp_valid_nxt  = '0;
        w_red_enable_nxt = 1'b0;
        w_red_coeff_nxt  = r_red_coeff;
        w_rsp_coeff_nxt  = r_rsp_coeff;
        w_grant          = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_grant          = 1'b1;
                    w_state_nxt      = WAIT;
                    w_id_nxt         = w_pick_id;
                    w_req_ready_nxt  = w_pick_onehot;
                    w_red_enable_nxt = 1'b1;
                    w_red_coeff_nxt  = req_coeff[int'(w_pick_id)*COEFF_W +: COEFF_W];
                end
            end
            WAIT: begin
                if (red_done) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = c_ONEHOT_LSB << r_id;
                    w_rsp_coeff_nxt = red_result;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id         <= '0;
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_red_enable <= 1'b0;
            r_red_coeff  <= '0;
            r_rsp_coeff  <= '0;
        end else begin
            r_id         <= w_id_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_red_enable <= w_red_enable_nxt;
            r_red_coeff  <= w_red_coeff_nxt;
            r_rsp_coeff  <= w_rsp_coeff_nxt;
        end
    end

`ifdef POLYVEC_REDUCE_ARB_RR_EN
    // Reset to the last index so the first search begins at requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_ptr <= w_pick_id;
        end
    end
`endif

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_coeff  = r_rsp_coeff;
    assign red_enable = r_red_enable;
    assign red_coeff  = r_red_coeff;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_polyvec_reduce_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_polyvec_reduce_arbiter
// Purpose  : Self-checking bench with a latency-3 mod-3329 reducer model.
// Revision : 1.0
// ============================================================================
module tb_polyvec_reduce_arbiter;

    localparam int RED_L = 3;
    localparam int RED_Q = 3329;

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] c0;
        logic [15:0] c1;
        int          id;
        logic [15:0] op;
        logic [15:0] res;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] coeff;
    } tx_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req_coeff;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_coeff;
    logic        red_enable;
    logic [15:0] red_coeff;
    logic        red_done;
    logic [15:0] red_result;
    logic        busy;

    logic        model_done, man_done;
    logic [15:0] model_result, man_result, red_op;
    bit          auto_red;

    logic [2:0]  req_valid3, req_ready3, rsp_valid3;
    logic [47:0] req_coeff3;
    logic [15:0] rsp_coeff3, red_coeff3, red_result3, red_op3;
    logic        red_enable3, red_done3, busy3;

    int n_tests, n_fail;
    logic [15:0] rq0[$];
    logic [15:0] rq1[$];
    vec_t tbl[6];

    assign red_done   = model_done | man_done;
    assign red_result = man_done ? man_result : model_result;

    polyvec_reduce_arbiter #(.NUM_REQ(2), .COEFF_W(16)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_coeff(req_coeff),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_coeff(rsp_coeff),
        .red_enable(red_enable), .red_coeff(red_coeff), .red_done(red_done),
        .red_result(red_result), .busy(busy)
    );

    polyvec_reduce_arbiter #(.NUM_REQ(3), .COEFF_W(16)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_coeff(req_coeff3),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_coeff(rsp_coeff3),
        .red_enable(red_enable3), .red_coeff(red_coeff3), .red_done(red_done3),
        .red_result(red_result3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reducer models: capture operand at launch, answer L cycles later.
    initial begin
        model_done = 1'b0; model_result = '0; red_op = '0;
        forever begin
            @(posedge clk); #1;
            if (auto_red && red_enable) begin
                red_op = red_coeff;
                repeat (RED_L) @(posedge clk);
                #1; model_done = 1'b1; model_result = 16'(int'(red_op) % RED_Q);
                @(posedge clk);
                #1; model_done = 1'b0;
            end
        end
    end

    initial begin
        red_done3 = 1'b0; red_result3 = '0; red_op3 = '0;
        forever begin
            @(posedge clk); #1;
            if (red_enable3) begin
                red_op3 = red_coeff3;
                repeat (RED_L) @(posedge clk);
                #1; red_done3 = 1'b1; red_result3 = 16'(int'(red_op3) % RED_Q);
                @(posedge clk);
                #1; red_done3 = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1; req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    // Spec-level arbitration rule over the set of requesters with work pending.
    function automatic int pick2(input bit [1:0] v, input int p);
`ifdef POLYVEC_REDUCE_ARB_RR_EN
        for (int k = 1; k <= 2; k++) if (v[(p + k) % 2]) return (p + k) % 2;
`else
        for (int i = 0; i < 2; i++) if (v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic drive_q();
        req_valid = {rq1.size() != 0, rq0.size() != 0};
        req_coeff = {(rq1.size() != 0) ? rq1[0] : 16'h0, (rq0.size() != 0) ? rq0[0] : 16'h0};
    endtask

    // Requesters drain rq0/rq1; expected grant order comes from the queue model.
    task automatic run_stream(input string tag);
        tx_t         expg[$];
        tx_t         expr[$];
        tx_t         e;
        logic [15:0] m0[$];
        logic [15:0] m1[$];
        int          mptr, w, last;
        do_reset();
        mptr = 1;
        m0 = rq0; m1 = rq1;
        while (m0.size() + m1.size() > 0) begin
            w = pick2({m1.size() != 0, m0.size() != 0}, mptr);
            e.id = w;
            e.coeff = (w == 0) ? m0.pop_front() : m1.pop_front();
            expg.push_back(e);
            mptr = w;
        end
        drive_q();
        last = -1;
        for (int c = 0; c < 600 && (expg.size() + expr.size()) > 0; c++) begin
            tick();
            if (req_ready != 2'b00) begin
                if (expg.size() == 0) begin
                    chk({tag, "_extra_grant"}, 64'(req_ready), 0);
                end else begin
                    e = expg.pop_front();
                    chk({tag, "_grant"}, 64'(req_ready), 64'(2'b01 << e.id));
                    chk({tag, "_op"}, 64'(red_coeff), 64'(e.coeff));
                    if (last >= 0) chk({tag, "_period"}, 64'(c - last), 5);
                    last = c;
                    e.coeff = 16'(int'(e.coeff) % RED_Q);
                    expr.push_back(e);
                end
                if (req_ready[0] && rq0.size() != 0) void'(rq0.pop_front());
                if (req_ready[1] && rq1.size() != 0) void'(rq1.pop_front());
            end
            if (rsp_valid != 2'b00) begin
                if (expr.size() == 0) begin
                    chk({tag, "_extra_rsp"}, 64'(rsp_valid), 0);
                end else begin
                    e = expr.pop_front();
                    chk({tag, "_rsp_id"}, 64'(rsp_valid), 64'(2'b01 << e.id));
                    chk({tag, "_rsp_val"}, 64'(rsp_coeff), 64'(e.coeff));
                end
            end
            drive_q();
        end
        chk({tag, "_drained"}, 64'(expg.size() + expr.size()), 0);
        req_valid = '0;
    endtask

    initial begin
        int          got, lat;
        int          exp3[4];
        int          idq3[$];
        int          id;
        logic [2:0]  one3;
        logic [1:0]  one2;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; req_valid = '0; req_coeff = '0; auto_red = 1'b1;
        man_done = 1'b0; man_result = '0; req_valid3 = '0; req_coeff3 = '0;
        one3 = 3'b001; one2 = 2'b01;
        repeat (3) tick();

        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_coeff", 64'(rsp_coeff), 0);
        chk("rst_red_enable", 64'(red_enable), 0);
        chk("rst_red_coeff", 64'(red_coeff), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_busy3", 64'(busy3), 0);
        reset = 1'b0;

        // Three requesters: requester 2 joins after requester 0's first grant.
`ifdef POLYVEC_REDUCE_ARB_RR_EN
        exp3[0] = 0; exp3[1] = 1; exp3[2] = 2; exp3[3] = 0;
`else
        exp3[0] = 0; exp3[1] = 0; exp3[2] = 0; exp3[3] = 0;
`endif
        req_valid3 = 3'b001;
        req_coeff3 = {16'd300, 16'd200, 16'd100};
        got = 0;
        for (int c = 0; c < 80 && (got < 4 || idq3.size() != 0); c++) begin
            tick();
            if (req_ready3 != 3'b000) begin
                if (got < 4) begin
                    chk("p3_grant", 64'(req_ready3), 64'(one3 << exp3[got]));
                    chk("p3_op", 64'(red_coeff3), 64'(100 * (exp3[got] + 1)));
                    idq3.push_back(exp3[got]);
                end
                got++;
                if (got == 1) req_valid3 = 3'b111;
                if (got >= 4) req_valid3 = 3'b000;
            end
            if (rsp_valid3 != 3'b000 && idq3.size() != 0) begin
                id = idq3.pop_front();
                chk("p3_rsp_id", 64'(rsp_valid3), 64'(one3 << id));
                chk("p3_rsp_val", 64'(rsp_coeff3), 64'(100 * (id + 1)));
            end
        end
        chk("p3_grant_count", 64'(got), 4);
        chk("p3_rsp_left", 64'(idq3.size()), 0);

        // Single-requester vectors: grant, launch, latency, result.
        tbl[0] = '{2'b01, 16'h0D01, 16'h1111, 0, 16'h0D01, 16'd0};
        tbl[1] = '{2'b10, 16'h2222, 16'd3330, 1, 16'd3330, 16'd1};
        tbl[2] = '{2'b01, 16'hFFFF, 16'd7, 0, 16'hFFFF, 16'd2284};
        tbl[3] = '{2'b10, 16'd5, 16'd3328, 1, 16'd3328, 16'd3328};
        tbl[4] = '{2'b01, 16'd10000, 16'd9, 0, 16'd10000, 16'd13};
        tbl[5] = '{2'b10, 16'd44, 16'd6659, 1, 16'd6659, 16'd1};
        for (int t = 0; t < 6; t++) begin
            req_valid = tbl[t].valid;
            req_coeff = {tbl[t].c1, tbl[t].c0};
            tick();
            chk("tbl_ready", 64'(req_ready), 64'(one2 << tbl[t].id));
            chk("tbl_enable", 64'(red_enable), 1);
            chk("tbl_op", 64'(red_coeff), 64'(tbl[t].op));
            chk("tbl_busy", 64'(busy), 1);
            req_valid = '0;
            req_coeff = 32'hA5A5_5A5A;
            tick();
            chk("tbl_enable_drop", 64'(red_enable), 0);
            chk("tbl_ready_drop", 64'(req_ready), 0);
            chk("tbl_op_hold", 64'(red_coeff), 64'(tbl[t].op));
            lat = 1;
            while (rsp_valid == 2'b00 && lat < 20) begin
                tick();
                lat++;
            end
            chk("tbl_latency", 64'(lat), 4);
            chk("tbl_rsp_id", 64'(rsp_valid), 64'(one2 << tbl[t].id));
            chk("tbl_rsp_val", 64'(rsp_coeff), 64'(tbl[t].res));
            tick();
            chk("tbl_rsp_pulse", 64'(rsp_valid), 0);
            chk("tbl_idle", 64'(busy), 0);
        end

        // Both requesters continuously valid, then random streams.
        rq0.delete(); rq1.delete();
        for (int i = 0; i < 4; i++) begin
            rq0.push_back(16'd3330);
            rq1.push_back(16'd6659);
        end
        run_stream("both");
        for (int s = 0; s < 4; s++) begin
            rq0.delete(); rq1.delete();
            for (int i = 0; i < int'($urandom_range(6, 0)); i++) rq0.push_back(16'($urandom));
            for (int i = 0; i < int'($urandom_range(6, 0)); i++) rq1.push_back(16'($urandom));
            run_stream("rand");
        end

        // Spurious done in IDLE, then req_valid churn while waiting.
        auto_red = 1'b0;
        do_reset();
        man_result = 16'h0123; man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("spur_rsp", 64'(rsp_valid), 0);
        chk("spur_busy", 64'(busy), 0);
        tick();
        chk("spur_ready", 64'(req_ready), 0);
        req_valid = 2'b01; req_coeff = {16'd11, 16'd777};
        tick();
        chk("churn_grant", 64'(req_ready), 1);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid = (k % 2 == 0) ? 2'b11 : 2'b10;
            req_coeff = $urandom;
            tick();
            if (req_ready != 2'b00 || red_enable) got++;
            chk("churn_op_hold", 64'(red_coeff), 777);
        end
        chk("churn_extra_grants", 64'(got), 0);
        chk("churn_busy", 64'(busy), 1);
        req_valid = '0;
        man_result = 16'hBEEF; man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("churn_rsp_id", 64'(rsp_valid), 1);
        chk("churn_rsp_passthru", 64'(rsp_coeff), 64'(16'hBEEF));
        tick();
        chk("churn_rsp_pulse", 64'(rsp_valid), 0);

        // Reset while waiting; the late done must be dropped.
        req_valid = 2'b01; req_coeff = {16'd5, 16'd9};
        tick();
        chk("mid_grant", 64'(req_ready), 1);
        req_valid = '0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_op", 64'(red_coeff), 0);
        chk("mid_rst_enable", 64'(red_enable), 0);
        chk("mid_rst_rsp", 64'(rsp_valid | req_ready), 0);
        tick();
        reset = 1'b0;
        man_result = 16'h0042; man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("late_done_rsp", 64'(rsp_valid), 0);
        chk("late_done_busy", 64'(busy), 0);
        req_valid = 2'b11;
        tick();
        chk("post_rst_grant", 64'(req_ready), 1);
        chk("post_rst_op", 64'(red_coeff), 9);
        req_valid = '0;
        man_result = 16'd9; man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("post_rst_rsp", 64'(rsp_valid), 1);
        tick();
        auto_red = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
